// File: rtl/fp_minmax_pkg.sv
// Shared definitions for the streaming floating-point min/max scanner:
// word/index width helpers, the scan state encoding and the signed-zero rule.
package fp_minmax_pkg;

    // Full word width of a float with the given exponent and mantissa fields
    function automatic int word_width(input int exp_w, input int man_w);
        return 1 + exp_w + man_w;
    endfunction

    // Channel index width, never narrower than one bit
    function automatic int index_width(input int n_ch);
        return (n_ch > 2) ? $clog2(n_ch) : 1;
    endfunction

    typedef enum logic {
        SCAN = 1'b0,
        HOLD = 1'b1
    } state_t;

    // A zero magnitude is always treated as positive, so +0 and -0 compare equal
    function automatic logic canon_sign(input logic sign, input logic mag_zero);
        return sign & ~mag_zero;
    endfunction

endpackage

// File: rtl/fp_less.sv
// Combinational a < b for raw float bit patterns. With SIGNED_CMP set the
// ordering is sign aware (negatives below positives, signed zeros equal);
// otherwise only the {exp,man} magnitude is compared.
module fp_less
    import fp_minmax_pkg::*;
#(
    parameter int EXP_W      = 8,
    parameter int MAN_W      = 23,
    parameter int SIGNED_CMP = 1,
    localparam int W         = word_width(EXP_W, MAN_W)
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         lt
);

    logic [W-2:0] mag_a;
    logic [W-2:0] mag_b;
    logic         sign_a;
    logic         sign_b;
    logic         mag_lt;
    logic         mag_gt;

    assign mag_a  = a[W-2:0];
    assign mag_b  = b[W-2:0];
    assign sign_a = canon_sign(a[W-1], mag_a == '0);
    assign sign_b = canon_sign(b[W-1], mag_b == '0);
    assign mag_lt = mag_a < mag_b;
    assign mag_gt = mag_a > mag_b;

    // Pick the ordering from the (canonical) signs; negatives invert magnitude order
    always_comb begin
        lt = mag_lt;
        if (SIGNED_CMP != 0) begin
            case ({sign_a, sign_b})
                2'b00:   lt = mag_lt;
                2'b10:   lt = 1'b1;
                2'b01:   lt = 1'b0;
                default: lt = mag_gt;
            endcase
        end
    end

endmodule

// File: rtl/fp_minmax_scan.sv
// Streaming min/max finder over vectors of N_CH floats. Elements are taken
// one per handshake; after the last one the extremes and their channel
// indices are held until the consumer takes them.
module fp_minmax_scan
    import fp_minmax_pkg::*;
#(
    parameter int EXP_W      = 8,
    parameter int MAN_W      = 23,
    parameter int N_CH       = 4,
    parameter int SIGNED_CMP = 1,
    localparam int W         = word_width(EXP_W, MAN_W),
    localparam int IDX_W     = index_width(N_CH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             abort,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_max,
    output logic [W-1:0]     out_min,
    output logic [IDX_W-1:0] out_max_idx,
    output logic [IDX_W-1:0] out_min_idx
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CH - 1);

    state_t           state;
    logic [IDX_W-1:0] count;
    logic             max_lt_new;
    logic             new_lt_min;
    logic             accept;

    // Running max is replaced only when strictly exceeded, so ties keep the earliest channel
    fp_less #(
        .EXP_W     (EXP_W),
        .MAN_W     (MAN_W),
        .SIGNED_CMP(SIGNED_CMP)
    ) u_max_cmp (
        .a (out_max),
        .b (in_data),
        .lt(max_lt_new)
    );

    fp_less #(
        .EXP_W     (EXP_W),
        .MAN_W     (MAN_W),
        .SIGNED_CMP(SIGNED_CMP)
    ) u_min_cmp (
        .a (in_data),
        .b (out_min),
        .lt(new_lt_min)
    );

    assign in_ready = (state == SCAN) && !abort;
    assign accept   = in_valid && in_ready;

    // Scan state, element counter and the running/held result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= SCAN;
            count       <= '0;
            out_valid   <= 1'b0;
            out_max     <= '0;
            out_min     <= '0;
            out_max_idx <= '0;
            out_min_idx <= '0;
        end else begin
            case (state)
                SCAN: begin
                    if (abort) begin
                        count <= '0;
                    end else if (accept) begin
                        if (count == '0) begin
                            out_max     <= in_data;
                            out_min     <= in_data;
                            out_max_idx <= '0;
                            out_min_idx <= '0;
                        end else begin
                            if (max_lt_new) begin
                                out_max     <= in_data;
                                out_max_idx <= count;
                            end
                            if (new_lt_min) begin
                                out_min     <= in_data;
                                out_min_idx <= count;
                            end
                        end
                        if (count == LAST_IDX) begin
                            state     <= HOLD;
                            out_valid <= 1'b1;
                            count     <= '0;
                        end else begin
                            count <= count + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state     <= SCAN;
                        out_valid <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp_minmax_scan.sv
// Scoreboard bench for fp_minmax_scan: a signed-ordering and a magnitude-only
// instance see identical stimulus; expected results are queued when a vector
// completes and popped by a monitor whenever a result handshake occurs.
module tb_fp_minmax_scan;

    localparam int N = 4;

    typedef struct {
        logic [31:0] mx;
        logic [31:0] mn;
        int          mxi;
        int          mni;
    } res_t;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic        abort     = 1'b0;
    logic        in_valid  = 1'b0;
    logic        out_ready = 1'b1;
    logic [31:0] in_data   = '0;

    logic        in_ready_s, out_valid_s, in_ready_u, out_valid_u;
    logic [31:0] max_s, min_s, max_u, min_u;
    logic [1:0]  maxi_s, mini_s, maxi_u, mini_u;

    res_t        q_s[$];
    res_t        q_u[$];
    int          total = 0;
    int          bad   = 0;
    logic [31:0] cur_vec [N];

    fp_minmax_scan #(.EXP_W(8), .MAN_W(23), .N_CH(N), .SIGNED_CMP(1)) dut (
        .clk(clk), .rst_n(rst_n), .abort(abort),
        .in_valid(in_valid), .in_ready(in_ready_s), .in_data(in_data),
        .out_valid(out_valid_s), .out_ready(out_ready),
        .out_max(max_s), .out_min(min_s),
        .out_max_idx(maxi_s), .out_min_idx(mini_s)
    );

    fp_minmax_scan #(.EXP_W(8), .MAN_W(23), .N_CH(N), .SIGNED_CMP(0)) dut_u (
        .clk(clk), .rst_n(rst_n), .abort(abort),
        .in_valid(in_valid), .in_ready(in_ready_u), .in_data(in_data),
        .out_valid(out_valid_u), .out_ready(out_ready),
        .out_max(max_u), .out_min(min_u),
        .out_max_idx(maxi_u), .out_min_idx(mini_u)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish, expected finish before 200000ns");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Ordering key as a plain signed number: negatives become negative magnitudes, -0 equals +0
    function automatic longint order_key(input logic [31:0] x, input bit signed_cmp);
        longint mag;
        mag = longint'(x[30:0]);
        if (signed_cmp && x[31]) return -mag;
        return mag;
    endfunction

    function automatic res_t model(input bit signed_cmp);
        res_t r;
        r.mx  = cur_vec[0];
        r.mn  = cur_vec[0];
        r.mxi = 0;
        r.mni = 0;
        for (int i = 1; i < N; i++) begin
            if (order_key(cur_vec[i], signed_cmp) > order_key(r.mx, signed_cmp)) begin
                r.mx  = cur_vec[i];
                r.mxi = i;
            end
            if (order_key(cur_vec[i], signed_cmp) < order_key(r.mn, signed_cmp)) begin
                r.mn  = cur_vec[i];
                r.mni = i;
            end
        end
        return r;
    endfunction

    function automatic logic [31:0] rand_elem();
        logic [31:0] pool [6];
        pool = '{32'h00000000, 32'h80000000, 32'h3F800000, 32'hBF800000, 32'h7F800000, 32'hFF800000};
        if ($urandom_range(0, 2) == 0) return pool[$urandom_range(0, 5)];
        return $urandom;
    endfunction

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_elem(input logic [31:0] d, input int gap, output bit ok);
        bit acc;
        ok = 1'b0;
        in_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        in_valid = 1'b1;
        in_data  = d;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            acc = in_ready_s;
            @(posedge clk);
            #1;
            if (acc) begin
                ok = 1'b1;
                break;
            end
        end
        in_valid = 1'b0;
        if (!ok) checkOutput("element accept timeout", 64'(ok), 64'd1);
    endtask

    task automatic applyStimulus(input int max_gap);
        bit   ok;
        bit   all_ok;
        res_t es;
        res_t eu;
        all_ok = 1'b1;
        es = model(1'b1);
        eu = model(1'b0);
        for (int i = 0; i < N; i++) begin
            send_elem(cur_vec[i], $urandom_range(0, max_gap), ok);
            if (!ok) all_ok = 1'b0;
        end
        if (all_ok) begin
            q_s.push_back(es);
            q_u.push_back(eu);
            checkOutput("valid latency signed", 64'(out_valid_s), 64'd1);
            checkOutput("valid latency magnitude", 64'(out_valid_u), 64'd1);
        end
    endtask

    // Monitor: result comparison on every output handshake plus stability while stalled
    logic        stall = 1'b0;
    logic [31:0] held_max, held_min;
    logic [1:0]  held_maxi, held_mini;
    always @(negedge clk) begin
        res_t e;
        if (!rst_n) begin
            stall = 1'b0;
        end else begin
            if (stall) begin
                checkOutput("stall out_valid", 64'(out_valid_s), 64'd1);
                checkOutput("stall in_ready", 64'(in_ready_s), 64'd0);
                checkOutput("stall out_max", 64'(max_s), 64'(held_max));
                checkOutput("stall out_min", 64'(min_s), 64'(held_min));
                checkOutput("stall max idx", 64'(maxi_s), 64'(held_maxi));
                checkOutput("stall min idx", 64'(mini_s), 64'(held_mini));
            end
            if (out_valid_s && out_ready) begin
                total++;
                if (q_s.size() == 0) begin
                    bad++;
                    $display("[TB] FAIL unexpected signed result: got out_valid=1 expected no result");
                end else begin
                    total--;
                    e = q_s.pop_front();
                    checkOutput("signed out_max", 64'(max_s), 64'(e.mx));
                    checkOutput("signed out_min", 64'(min_s), 64'(e.mn));
                    checkOutput("signed max idx", 64'(maxi_s), 64'(e.mxi));
                    checkOutput("signed min idx", 64'(mini_s), 64'(e.mni));
                end
            end
            if (out_valid_u && out_ready) begin
                total++;
                if (q_u.size() == 0) begin
                    bad++;
                    $display("[TB] FAIL unexpected magnitude result: got out_valid=1 expected no result");
                end else begin
                    total--;
                    e = q_u.pop_front();
                    checkOutput("magnitude out_max", 64'(max_u), 64'(e.mx));
                    checkOutput("magnitude out_min", 64'(min_u), 64'(e.mn));
                    checkOutput("magnitude max idx", 64'(maxi_u), 64'(e.mxi));
                    checkOutput("magnitude min idx", 64'(mini_u), 64'(e.mni));
                end
            end
            stall     = out_valid_s && !out_ready;
            held_max  = max_s;
            held_min  = min_s;
            held_maxi = maxi_s;
            held_mini = mini_s;
        end
    end

    task automatic check_reset_values(input string tag);
        checkOutput({tag, " in_ready"}, 64'(in_ready_s), 64'd1);
        checkOutput({tag, " in_ready magnitude"}, 64'(in_ready_u), 64'd1);
        checkOutput({tag, " out_valid"}, 64'(out_valid_s), 64'd0);
        checkOutput({tag, " out_max"}, 64'(max_s), 64'd0);
        checkOutput({tag, " out_min"}, 64'(min_s), 64'd0);
        checkOutput({tag, " max idx"}, 64'(maxi_s), 64'd0);
        checkOutput({tag, " min idx"}, 64'(mini_s), 64'd0);
    endtask

    initial begin
        bit ok;

        rst_n = 1'b0;
        wait_cycles(3);
        check_reset_values("reset");
        rst_n = 1'b1;
        wait_cycles(1);

        // Basic vector, with literal expectations as well as the model
        cur_vec = '{32'h3F800000, 32'h40000000, 32'hC0400000, 32'h3F000000};
        applyStimulus(0);
        checkOutput("basic max", 64'(max_s), 64'h40000000);
        checkOutput("basic max idx", 64'(maxi_s), 64'd1);
        checkOutput("basic min", 64'(min_s), 64'hC0400000);
        checkOutput("basic min idx", 64'(mini_s), 64'd2);
        checkOutput("magnitude max", 64'(max_u), 64'hC0400000);
        checkOutput("magnitude max idx", 64'(maxi_u), 64'd2);
        checkOutput("magnitude min", 64'(min_u), 64'h3F000000);
        checkOutput("magnitude min idx", 64'(mini_u), 64'd3);

        // Ties keep the earliest channel
        cur_vec = '{32'h40000000, 32'h40000000, 32'h3F800000, 32'h3F800000};
        applyStimulus(0);
        checkOutput("tie max idx", 64'(maxi_s), 64'd0);
        checkOutput("tie min idx", 64'(mini_s), 64'd2);

        // Signed zeros are equal
        cur_vec = '{32'h80000000, 32'h00000000, 32'h3F800000, 32'h3F800000};
        applyStimulus(0);
        checkOutput("zero min", 64'(min_s), 64'h80000000);
        checkOutput("zero min idx", 64'(mini_s), 64'd0);
        checkOutput("zero max", 64'(max_s), 64'h3F800000);
        checkOutput("zero max idx", 64'(maxi_s), 64'd2);
        wait_cycles(2);

        // Backpressure: result held for five cycles, then next vector with gaps
        out_ready = 1'b0;
        cur_vec = '{32'h3F800000, 32'h40000000, 32'hC0400000, 32'h3F000000};
        applyStimulus(0);
        repeat (5) begin
            @(negedge clk);
            checkOutput("backpressure out_valid", 64'(out_valid_s), 64'd1);
            checkOutput("backpressure in_ready", 64'(in_ready_s), 64'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        wait_cycles(1);
        checkOutput("in_ready after handshake", 64'(in_ready_s), 64'd1);
        checkOutput("out_valid after handshake", 64'(out_valid_s), 64'd0);
        applyStimulus(3);
        wait_cycles(2);

        // Abort after two elements, then a complete new vector
        for (int i = 0; i < N; i++) cur_vec[i] = rand_elem();
        for (int i = 0; i < 2; i++) send_elem(cur_vec[i], 0, ok);
        abort = 1'b1;
        @(negedge clk);
        checkOutput("abort blocks in_ready", 64'(in_ready_s), 64'd0);
        @(posedge clk);
        #1;
        abort = 1'b0;
        cur_vec = '{32'hBF000000, 32'h41200000, 32'h00000000, 32'hC1200000};
        applyStimulus(0);
        wait_cycles(2);

        // Abort coincident with the last element: no result
        for (int i = 0; i < N; i++) cur_vec[i] = rand_elem();
        for (int i = 0; i < 3; i++) send_elem(cur_vec[i], 0, ok);
        in_valid = 1'b1;
        in_data  = cur_vec[3];
        abort    = 1'b1;
        @(negedge clk);
        checkOutput("abort on last in_ready", 64'(in_ready_s), 64'd0);
        @(posedge clk);
        #1;
        abort    = 1'b0;
        in_valid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            checkOutput("no result after abort", 64'(out_valid_s), 64'd0);
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) cur_vec[i] = rand_elem();
        applyStimulus(1);
        wait_cycles(2);

        // Reset mid-vector
        cur_vec = '{32'h3F800000, 32'h40000000, 32'hC0400000, 32'h3F000000};
        for (int i = 0; i < 2; i++) send_elem(cur_vec[i], 0, ok);
        rst_n = 1'b0;
        #1;
        check_reset_values("reset mid-vector");
        wait_cycles(2);
        rst_n = 1'b1;
        wait_cycles(1);

        // Reset while holding a result
        out_ready = 1'b0;
        applyStimulus(0);
        wait_cycles(1);
        rst_n = 1'b0;
        #1;
        check_reset_values("reset in hold");
        if (q_s.size() != 0) void'(q_s.pop_back());
        if (q_u.size() != 0) void'(q_u.pop_back());
        out_ready = 1'b1;
        wait_cycles(2);
        rst_n = 1'b1;
        wait_cycles(1);

        // Random vectors with random input gaps
        for (int v = 0; v < 25; v++) begin
            for (int i = 0; i < N; i++) cur_vec[i] = rand_elem();
            applyStimulus(2);
        end

        for (int t = 0; t < 20 && (q_s.size() != 0 || q_u.size() != 0); t++) @(posedge clk);
        #1;
        checkOutput("scoreboard drained", 64'(q_s.size() + q_u.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
